// File: rtl/bsg_comm_link_striper_if.sv
// rtl/bsg_comm_link_striper_if.sv - fused core port and per-channel link port bundle
interface bsg_comm_link_striper_if #(
    parameter int channel_width_p = 16,
    parameter int core_channels_p = 4,
    parameter int link_channels_p = 4
);
    logic                                       fused_valid_i;
    logic [channel_width_p*core_channels_p-1:0] fused_data_i;
    logic                                       fused_ready_o;
    logic [link_channels_p-1:0]                 valid_o;
    logic [channel_width_p-1:0]                 data_o [link_channels_p];
    logic [link_channels_p-1:0]                 ready_i;

    // The striper itself.
    modport slave (
        input  fused_valid_i, fused_data_i, ready_i,
        output fused_ready_o, valid_o, data_o
    );

    // The core source plus the sbox sink around the striper.
    modport master (
        output fused_valid_i, fused_data_i, ready_i,
        input  fused_ready_o, valid_o, data_o
    );
endinterface

// File: rtl/bsg_comm_link_striper.sv
// rtl/bsg_comm_link_striper.sv - round-robin striper of fused words across active link channels
module bsg_comm_link_striper #(
    parameter int channel_width_p = 16,
    parameter int core_channels_p = 4,
    parameter int link_channels_p = 4,
    localparam int TW = (link_channels_p > 1) ? $clog2(link_channels_p) : 1
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic                          calib_done_i,
    input  logic [TW-1:0]                 top_active_channel_i,
    bsg_comm_link_striper_if.slave        link
);
    localparam int W  = channel_width_p;
    localparam int C  = core_channels_p;
    localparam int L  = link_channels_p;
    localparam int FW = W * C;
    localparam int IW = (C > 1) ? $clog2(C) : 1;
    // Wide enough for idx+R, ptr+R and channel offsets without overflow.
    localparam int AW = $clog2(C + 2*L + 2) + 2;

    logic [FW-1:0] r_data;
    logic          r_full;
    logic [IW-1:0] r_idx;
    logic [TW-1:0] r_ptr;
    logic [L-1:0]  r_sent;

    logic [AW-1:0] w_n;
    logic [AW-1:0] w_rem;
    logic [AW-1:0] w_r;
    logic [AW-1:0] w_sum;
    logic [AW-1:0] w_ptr_next;
    logic [AW-1:0] w_idx_next;
    logic [AW-1:0] w_k [L];
    logic [L-1:0]  w_win;
    logic [L-1:0]  w_valid;
    logic [L-1:0]  w_xfer;
    logic          w_live;
    logic          w_done;
    logic          w_final;
    logic          w_accept;

    // Round window size and the pointer/index values after this round.
    always_comb begin
        w_n        = AW'(top_active_channel_i) + AW'(1);
        w_rem      = AW'(C) - AW'(r_idx);
        w_r        = (w_n < w_rem) ? w_n : w_rem;
        w_sum      = AW'(r_ptr) + w_r;
        w_ptr_next = (w_sum >= w_n) ? (w_sum - w_n) : w_sum;
        w_idx_next = AW'(r_idx) + w_r;
        w_live     = r_full & calib_done_i & ~reset_i;
    end

    // Map each channel to its window offset; unsent window channels present a piece.
    always_comb begin
        for (int c = 0; c < L; c++) begin
            w_k[c]         = (AW'(c) >= AW'(r_ptr)) ? (AW'(c) - AW'(r_ptr))
                                                    : (AW'(c) + w_n - AW'(r_ptr));
            w_win[c]       = (AW'(c) < w_n) && (w_k[c] < w_r);
            w_valid[c]     = w_live & w_win[c] & ~r_sent[c];
            w_xfer[c]      = w_valid[c] & link.ready_i[c];
            link.data_o[c] = w_valid[c] ? W'(r_data >> ((int'(r_idx) + int'(w_k[c])) * W)) : '0;
        end
    end

    // Round completes once every window channel is sent, earlier or now.
    always_comb begin
        w_done             = w_live & (&(~w_win | r_sent | w_xfer));
        w_final            = w_done & (w_idx_next == AW'(C));
        link.fused_ready_o = calib_done_i & ~reset_i & (~r_full | w_final);
        w_accept           = link.fused_valid_i & link.fused_ready_o;
        link.valid_o       = w_valid;
    end

    // Control state: word occupancy, piece index, rotation pointer, sent mask.
    always_ff @(posedge clk_i) begin
        if (reset_i || !calib_done_i) begin
            r_full <= 1'b0;
            r_idx  <= '0;
            r_ptr  <= '0;
            r_sent <= '0;
        end else begin
            if (w_done) begin
                r_sent <= '0;
                r_ptr  <= TW'(w_ptr_next);
                r_idx  <= w_final ? '0 : IW'(w_idx_next);
                if (w_final) begin
                    r_full <= 1'b0;
                end
            end else begin
                r_sent <= r_sent | w_xfer;
            end
            if (w_accept) begin
                r_full <= 1'b1;
                r_idx  <= '0;
            end
        end
    end

    // Word buffer; contents only matter while r_full is set.
    always_ff @(posedge clk_i) begin
        if (w_accept) begin
            r_data <= link.fused_data_i;
        end
    end
endmodule

// File: tb/tb_bsg_comm_link_striper.sv
// tb/tb_bsg_comm_link_striper.sv - randomized self-checking bench for bsg_comm_link_striper
module tb_bsg_comm_link_striper;
    localparam int W = 16;
    localparam int C = 4;
    localparam int L = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       calib;
    logic [1:0] top;

    bsg_comm_link_striper_if #(.channel_width_p(W), .core_channels_p(C), .link_channels_p(L)) bus ();

    bsg_comm_link_striper #(.channel_width_p(W), .core_channels_p(C), .link_channels_p(L)) dut (
        .clk_i                (clk),
        .reset_i              (reset),
        .calib_done_i         (calib),
        .top_active_channel_i (top),
        .link                 (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Reference model: queue of pieces still to be striped plus the channel
    // assignment of the round currently on the wire.
    int          m_q[$];
    bit          m_have [L];
    logic [15:0] m_piece [L];
    int          m_ptr;

    function automatic bit m_busy();
        for (int c = 0; c < L; c++) if (m_have[c]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic void m_load_round(input int n);
        int r;
        r = (m_q.size() < n) ? m_q.size() : n;
        for (int k = 0; k < r; k++) begin
            m_have[(m_ptr + k) % n]  = 1'b1;
            m_piece[(m_ptr + k) % n] = 16'(m_q.pop_front());
        end
        m_ptr = (m_ptr + r) % n;
    endfunction

    function automatic void m_clear();
        m_q.delete();
        for (int c = 0; c < L; c++) m_have[c] = 1'b0;
        m_ptr = 0;
    endfunction

    logic [3:0]  e_valid;
    logic [63:0] e_data;
    logic        e_ready;

    task automatic compute_and_check(input string tag);
        bit allow, round_end;
        logic [63:0] got_data;
        allow     = calib && !reset;
        round_end = m_busy();
        e_valid   = '0;
        e_data    = '0;
        for (int c = 0; c < L; c++) begin
            if (allow && m_have[c]) begin
                e_valid[c]       = 1'b1;
                e_data[c*16 +: 16] = m_piece[c];
                if (!bus.ready_i[c]) round_end = 1'b0;
            end
        end
        e_ready = allow && (!m_busy() || (round_end && m_q.size() == 0));
        got_data = {bus.data_o[3], bus.data_o[2], bus.data_o[1], bus.data_o[0]};
        check({tag, "_valid"}, 64'(bus.valid_o), 64'(e_valid));
        check({tag, "_data"}, got_data, e_data);
        check({tag, "_fready"}, 64'(bus.fused_ready_o), 64'(e_ready));
    endtask

    function automatic void m_step();
        bit was_busy;
        int n;
        n = int'(top) + 1;
        if (reset || !calib) begin
            m_clear();
            return;
        end
        was_busy = m_busy();
        for (int c = 0; c < L; c++) if (m_have[c] && bus.ready_i[c]) m_have[c] = 1'b0;
        if (was_busy && !m_busy() && m_q.size() > 0) m_load_round(n);
        if (bus.fused_valid_i && e_ready) begin
            for (int k = 0; k < C; k++) m_q.push_back(int'(bus.fused_data_i[k*16 +: 16]));
            m_load_round(n);
        end
    endfunction

    initial begin
        int ready_mode;
        reset = 1'b1;
        calib = 1'b0;
        top   = 2'd3;
        bus.fused_valid_i = 1'b0;
        bus.fused_data_i  = '0;
        bus.ready_i       = '1;
        m_clear();
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_valid", 64'(bus.valid_o), 64'd0);
        check("rst_data", {bus.data_o[3], bus.data_o[2], bus.data_o[1], bus.data_o[0]}, 64'd0);
        check("rst_fready", 64'(bus.fused_ready_o), 64'd0);

        for (int ph = 0; ph < 40; ph++) begin
            ready_mode = ph % 3;
            top = 2'($urandom_range(0, 3));
            for (int cyc = 0; cyc < 150; cyc++) begin
                @(negedge clk);
                reset = ($urandom_range(0, 99) == 0);
                calib = (cyc != 0) && ($urandom_range(0, 99) != 0);
                if (!calib) top = 2'($urandom_range(0, 3));
                bus.fused_valid_i = ($urandom_range(0, 3) != 0);
                bus.fused_data_i  = {$urandom(), $urandom()};
                case (ready_mode)
                    0:       bus.ready_i = '1;
                    1:       bus.ready_i = 4'($urandom());
                    default: bus.ready_i = 4'($urandom()) | 4'($urandom());
                endcase
                #1;
                compute_and_check("cyc");
                m_step();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
